// File: rtl/sig_gen_pkg.sv
// Shared widths, FSM state encoding and fixed-point helpers for the test-signal generators.
package sig_gen_pkg;

  localparam int DATA_W    = 14;
  localparam int PER_W     = 16;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 30;
  localparam int DIV_ITER  = 31;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [ACC_W-1:0] level_to_acc(input logic [DATA_W-1:0] lvl);
    return {lvl, {FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/unsigned_serial_divider.sv
// Restoring divider, one quotient bit per clock; a new start always restarts it.
module unsigned_serial_divider
  import sig_gen_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [DIV_ITER-1:0] dividend,
  input  logic [PER_W-1:0]    divisor,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    quotient
);

  localparam logic [CNT_W-1:0] ITER_LD = CNT_W'(DIV_ITER);

  // dq_q shifts the dividend out at the top while quotient bits enter at the bottom
  logic [DIV_ITER-1:0] dq_q, dq_d;
  logic [PER_W-1:0]    rem_q, rem_d;
  logic [PER_W-1:0]    dsr_q, dsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [PER_W:0]      shifted;
  logic [PER_W:0]      diff;
  logic                ge;

  always_comb begin
    shifted = {rem_q, dq_q[DIV_ITER-1]};
    diff    = shifted - {1'b0, dsr_q};
    ge      = (shifted >= {1'b0, dsr_q});

    dq_d   = dq_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start) begin
      dq_d   = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
      cnt_d  = ITER_LD;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? diff[PER_W-1:0] : shifted[PER_W-1:0];
      dq_d  = {dq_q[DIV_ITER-2:0], ge};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dq_q   <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = dq_q[ACC_W-1:0];

endmodule

// File: rtl/triangle_ref_generator.sv
// Periodic 14-bit triangle reference with programmable period and levels, plus a
// ground-truth zero-cross strobe on the rising-slope midpoint sample.
//
// state | meaning
// IDLE  | outputs quiet; config latched and checked when enable is seen high
// CALC  | serial division of the level span by the period to get the slope step
// RUN   | one sample per clock, phase counter wraps every N clocks
module triangle_ref_generator
  import sig_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [PER_W-1:0]  ptos_x_ciclo,
  input  logic [DATA_W-1:0] min_level,
  input  logic [DATA_W-1:0] max_level,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              zero_cross,
  output logic              cfg_error
);

  state_e              state_q, state_d;
  logic [PER_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [ACC_W-1:0]    step_q, step_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PER_W-1:0]    phase_q, phase_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                zc_q, zc_d;
  logic                err_q, err_d;

  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [ACC_W-1:0]    div_quot;
  logic [DATA_W-1:0]   span;
  logic [DIV_ITER-1:0] div_dividend;
  logic                cfg_bad;

  logic [PER_W-1:0]    half;
  logic [PER_W-1:0]    quarter;
  logic [PER_W-1:0]    phase_nxt;
  logic [ACC_W-1:0]    min_acc;
  logic [ACC_W-1:0]    max_acc;
  logic [ACC_W:0]      rise_sum;
  logic [ACC_W-1:0]    fall_room;
  logic [ACC_W-1:0]    acc_nxt;

  // Span shifted by FRAC_BITS+1 because the step covers half a period per slope
  assign span         = max_level - min_level;
  assign div_dividend = {span, {(FRAC_BITS+1){1'b0}}};
  assign cfg_bad      = (ptos_x_ciclo < PER_W'(4)) || (max_level < min_level);

  unsigned_serial_divider u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (ptos_x_ciclo),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    half      = n_q >> 1;
    quarter   = n_q >> 2;
    phase_nxt = (phase_q == n_q - PER_W'(1)) ? '0 : phase_q + PER_W'(1);
    min_acc   = level_to_acc(min_q);
    max_acc   = level_to_acc(max_q);
    rise_sum  = {1'b0, acc_q} + {1'b0, step_q};
    fall_room = acc_q - min_acc;

    // Forced exact values at phase 0 and the peak keep truncation error from accumulating
    if (phase_nxt == '0) begin
      acc_nxt = min_acc;
    end else if (phase_nxt < half) begin
      acc_nxt = (rise_sum > {1'b0, max_acc}) ? max_acc : rise_sum[ACC_W-1:0];
    end else if (phase_nxt == half) begin
      acc_nxt = max_acc;
    end else begin
      acc_nxt = (step_q > fall_room) ? min_acc : acc_q - step_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    min_d     = min_q;
    max_d     = max_q;
    step_d    = step_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    zc_d      = 1'b0;
    err_d     = err_q;
    div_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          n_d   = ptos_x_ciclo;
          min_d = min_level;
          max_d = max_level;
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            div_start = 1'b1;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (div_done && !div_busy) begin
          step_d  = div_quot;
          acc_d   = min_acc;
          phase_d = '0;
          data_d  = min_q;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_nxt;
          phase_d = phase_nxt;
          data_d  = acc_nxt[ACC_W-1:FRAC_BITS];
          valid_d = 1'b1;
          zc_d    = (phase_nxt == quarter);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      min_q   <= '0;
      max_q   <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      phase_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      zc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      min_q   <= min_d;
      max_q   <= max_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      zc_q    <= zc_d;
      err_q   <= err_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign zero_cross = zc_q;
  assign cfg_error  = err_q;

endmodule
